fp_check: RTL and testbench
===========================

# fp_check

Synthesizable response checker that sits directly downstream of `fp_unit`, consuming its `fp_exe_o` result stream. Expected results and flags are queued when an operation is issued to `fp_unit`. Each response from `fp_unit` is matched in order against the queue head using the NaN-canonical comparison rule. The block keeps pass/fail statistics and captures the first mismatch, so self-checking runs on FPGA or emulation need no host-side file compare.

## Interface
Parameters:
- `DEPTH`, 8: expected-entry FIFO depth; power of two, 2..64.

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `issue_valid`  in  1  an operation is issued to `fp_unit` this cycle.
- `issue_ready`  out  1  FIFO can accept an entry.
- `issue_result`  in  64  expected result.
- `issue_flags`  in  5  expected fflags (NV,DZ,OF,UF,NX).
- `issue_fmt`  in  2  0 = single, 1 = double.
- `issue_nan_chk`  in  1  1 when the op is neither `fcmp` nor `fcvt_f2i`; enables NaN masking.
- `resp_valid`  in  1  `fp_unit` output `ready`.
- `resp_result`  in  64  `fp_exe_o.result`.
- `resp_flags`  in  5  `fp_exe_o.flags`.
- `pass_count`  out  32  matched responses.
- `fail_count`  out  32  mismatched responses.
- `fail`  out  1  sticky; first mismatch captured.
- `fail_ref_result`, `fail_calc_result`  out  64  captured operands of the first mismatch.
- `fail_ref_flags`, `fail_calc_flags`  out  5  captured flags of the first mismatch.
- `overflow`  out  1  sticky; issue attempted while `issue_ready` was low.
- `underflow`  out  1  sticky; response arrived with the FIFO empty.
- `idle`  out  1  FIFO empty and compare stage empty.

## Operation
- Push: an entry {result, flags, fmt, nan_chk} is written when `issue_valid && issue_ready`.
- `issue_ready = !full`. If `issue_ready` is low, it stays low even when a pop occurs in the same cycle (no full-bypass).
- Pop: on `resp_valid` with the FIFO non-empty, the head entry and the response are registered into the compare stage.
- `resp_valid` with the FIFO empty:
  - sets `underflow`;
  - the response is dropped;
  - this holds even when a push occurs in the same cycle (no empty-bypass).
- Compare rule, fmt 0 (single), low 32 bits only:
  - if `nan_chk` and calc[31:0] = 0x7FC00000, compare only bits [30:22];
  - otherwise compare bits [31:0].
- Compare rule, fmt 1 (double):
  - if `nan_chk` and calc = 0x7FF8000000000000, compare only bits [62:51];
  - otherwise compare all 64 bits.
- Flags are always compared in full.
- A match increments `pass_count`. A mismatch increments `fail_count`.
- Both counters saturate at 0xFFFFFFFF.
- The first mismatch sets `fail` and loads the four `fail_*` registers. Later mismatches do not overwrite them.
- FSM states:
  - RUN: normal operation.
  - HALT: entered on the first mismatch, only when FP_CHECK_HALT_EN is defined.
  - Leaving either state is possible only via `reset`.
- Reset values:
  - all counters, stickies and `fail_*` registers = 0;
  - FIFO empty, so `idle` = 1 and `issue_ready` = 1;
  - state = RUN.
- Reset mid-operation discards all queued entries and any in-flight compare.

## Timing
- Push visible at the FIFO head the cycle after the write edge.
- Compare latency is 2 cycles:
  - `resp_valid` sampled at edge t (compare stage loaded);
  - counters and `fail` update at edge t+1.
- One response per cycle sustained; throughput matches back-to-back `fp_unit` outputs.
- Pointers are `$clog2(DEPTH)+1` bits with a wrap bit:
  - full = indices equal and wrap bits differ;
  - empty = pointers equal.
- `idle` = FIFO empty && compare stage empty.

## Configuration
- `FP_CHECK_HALT_EN` defined:
  - the first mismatch enters HALT;
  - `issue_ready` is forced low;
  - responses are ignored; counters freeze; `overflow` and `underflow` stop updating.
- `FP_CHECK_HALT_EN` undefined:
  - HALT does not exist;
  - checking continues after the first failure and `fail_count` keeps counting.

## Structure
- The `fp_wire` package gains:
  - `fp_check_entry_type` (packed struct: result, flags, fmt, nan_chk);
  - constants `FP_CANON_NAN32` = 0x7FC00000 and `FP_CANON_NAN64` = 0x7FF8000000000000.
- One sub-module, `fp_check_fifo`: parameterised synchronous FIFO of `fp_check_entry_type`.
- Compare stage, counters and FSM live in `fp_check`.

## Test plan
- **In-order single match:** issue fmt 0, result 0x3F800000, flags 0; response 0x3F800000, flags 0 two cycles later -> `pass_count` = 1, `fail` = 0, `idle` = 1.
- **Single-precision NaN mask:** issue fmt 0, nan_chk 1, result 0x7FC12345; response 0x7FC00000 -> pass. Repeat with nan_chk 0 -> `fail` = 1, `fail_ref_result` = 0x7FC12345.
- **Flag mismatch (double):** issue fmt 1, result 0x3FF0000000000000, flags 0x01; response with the same result, flags 0x00 -> `fail_count` = 1, `fail_ref_flags` = 0x01, `fail_calc_flags` = 0x00.
- **Boundaries:**
  - DEPTH pushes with no response -> `issue_ready` = 0;
  - one further `issue_valid` -> `overflow` = 1;
  - `resp_valid` on an empty FIFO with a same-cycle push -> `underflow` = 1 and the pushed entry stays queued.
- **HALT (macro defined):** a mismatch followed by 3 matching responses -> `pass_count` unchanged and `issue_ready` = 0. Then assert `reset` for 1 cycle -> all outputs return to their reset values.

Source files
------------

// File: rtl/fp_check_pkg.sv
// fp_wire: shared types and constants for the fp_check response checker.
package fp_wire;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
        logic [1:0]  fmt;
        logic        nan_chk;
    } fp_check_entry_type;

    localparam logic [31:0] FP_CANON_NAN32 = 32'h7FC0_0000;
    localparam logic [63:0] FP_CANON_NAN64 = 64'h7FF8_0000_0000_0000;

    typedef enum logic {RUN, HALT} fp_check_state_e;

endpackage

// File: rtl/fp_check_fifo.sv
// fp_check_fifo: synchronous FIFO of expected entries, pointers carry a wrap bit.
module fp_check_fifo
    import fp_wire::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  fp_check_entry_type push_data,
    input  logic               pop,
    output fp_check_entry_type pop_data,
    output logic               full,
    output logic               empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    fp_check_entry_type mem_q [DEPTH];

    always_comb begin
        full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        empty    = wr_ptr_q == rd_ptr_q;
        wr_ptr_d = (push && !full) ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = (pop && !empty) ? rd_ptr_q + 1'b1 : rd_ptr_q;
        pop_data = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full)
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fp_check.sv
// fp_check: in-order fp_unit response checker with stats and first-mismatch capture.
// Define FP_CHECK_HALT_EN to freeze the checker on the first mismatch.
module fp_check
    import fp_wire::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [63:0] issue_result,
    input  logic [4:0]  issue_flags,
    input  logic [1:0]  issue_fmt,
    input  logic        issue_nan_chk,
    input  logic        resp_valid,
    input  logic [63:0] resp_result,
    input  logic [4:0]  resp_flags,
    output logic [31:0] pass_count,
    output logic [31:0] fail_count,
    output logic        fail,
    output logic [63:0] fail_ref_result,
    output logic [63:0] fail_calc_result,
    output logic [4:0]  fail_ref_flags,
    output logic [4:0]  fail_calc_flags,
    output logic        overflow,
    output logic        underflow,
    output logic        idle
);
    fp_check_state_e    state_q, state_d;
    fp_check_entry_type head, cmp_exp_q, cmp_exp_d;
    logic [63:0]        cmp_result_q, cmp_result_d, fail_ref_result_q, fail_ref_result_d;
    logic [63:0]        fail_calc_result_q, fail_calc_result_d;
    logic [4:0]         cmp_flags_q, cmp_flags_d, fail_ref_flags_q, fail_ref_flags_d;
    logic [4:0]         fail_calc_flags_q, fail_calc_flags_d;
    logic [31:0]        pass_count_q, pass_count_d, fail_count_q, fail_count_d;
    logic               cmp_valid_q, cmp_valid_d, fail_q, fail_d;
    logic               overflow_q, overflow_d, underflow_q, underflow_d;
    logic               run, full, empty, push, pop;
    logic               is_dbl, nan_hit, result_ok, check, match, first;

    assign run  = state_q == RUN;
    assign push = issue_valid && issue_ready;
    assign pop  = resp_valid && !empty && run;

    fp_check_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ('{issue_result, issue_flags, issue_fmt, issue_nan_chk}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    // A canonical NaN from the unit only has to agree on exponent and quiet bit.
    always_comb begin
        is_dbl    = cmp_exp_q.fmt == 2'd1;
        nan_hit   = cmp_exp_q.nan_chk && (is_dbl ? cmp_result_q == FP_CANON_NAN64
                                                 : cmp_result_q[31:0] == FP_CANON_NAN32);
        result_ok = is_dbl ? (nan_hit ? cmp_exp_q.result[62:51] == cmp_result_q[62:51]
                                      : cmp_exp_q.result == cmp_result_q)
                           : (nan_hit ? cmp_exp_q.result[30:22] == cmp_result_q[30:22]
                                      : cmp_exp_q.result[31:0] == cmp_result_q[31:0]);
        check     = cmp_valid_q && run;
        match     = result_ok && cmp_exp_q.flags == cmp_flags_q;
        first     = check && !match && !fail_q;
    end

    always_comb begin
        state_d            = state_q;
        cmp_valid_d        = pop;
        cmp_exp_d          = pop ? head : cmp_exp_q;
        cmp_result_d       = pop ? resp_result : cmp_result_q;
        cmp_flags_d        = pop ? resp_flags : cmp_flags_q;
        pass_count_d       = (check && match && pass_count_q != '1) ? pass_count_q + 1'b1 : pass_count_q;
        fail_count_d       = (check && !match && fail_count_q != '1) ? fail_count_q + 1'b1 : fail_count_q;
        fail_d             = fail_q || (check && !match);
        fail_ref_result_d  = first ? cmp_exp_q.result : fail_ref_result_q;
        fail_calc_result_d = first ? cmp_result_q : fail_calc_result_q;
        fail_ref_flags_d   = first ? cmp_exp_q.flags : fail_ref_flags_q;
        fail_calc_flags_d  = first ? cmp_flags_q : fail_calc_flags_q;
        overflow_d         = overflow_q || (run && issue_valid && !issue_ready);
        underflow_d        = underflow_q || (run && resp_valid && empty);
`ifdef FP_CHECK_HALT_EN
        state_d            = (check && !match) ? HALT : state_q;
`else
        state_d            = state_q;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q            <= RUN;
            cmp_valid_q        <= 1'b0;
            cmp_exp_q          <= '0;
            cmp_result_q       <= '0;
            cmp_flags_q        <= '0;
            pass_count_q       <= '0;
            fail_count_q       <= '0;
            fail_q             <= 1'b0;
            fail_ref_result_q  <= '0;
            fail_calc_result_q <= '0;
            fail_ref_flags_q   <= '0;
            fail_calc_flags_q  <= '0;
            overflow_q         <= 1'b0;
            underflow_q        <= 1'b0;
        end else begin
            state_q            <= state_d;
            cmp_valid_q        <= cmp_valid_d;
            cmp_exp_q          <= cmp_exp_d;
            cmp_result_q       <= cmp_result_d;
            cmp_flags_q        <= cmp_flags_d;
            pass_count_q       <= pass_count_d;
            fail_count_q       <= fail_count_d;
            fail_q             <= fail_d;
            fail_ref_result_q  <= fail_ref_result_d;
            fail_calc_result_q <= fail_calc_result_d;
            fail_ref_flags_q   <= fail_ref_flags_d;
            fail_calc_flags_q  <= fail_calc_flags_d;
            overflow_q         <= overflow_d;
            underflow_q        <= underflow_d;
        end
    end

    assign issue_ready      = !full && run;
    assign pass_count       = pass_count_q;
    assign fail_count       = fail_count_q;
    assign fail             = fail_q;
    assign fail_ref_result  = fail_ref_result_q;
    assign fail_calc_result = fail_calc_result_q;
    assign fail_ref_flags   = fail_ref_flags_q;
    assign fail_calc_flags  = fail_calc_flags_q;
    assign overflow         = overflow_q;
    assign underflow        = underflow_q;
    assign idle             = empty && !cmp_valid_q;

endmodule

// File: tb/tb_fp_check.sv
// tb_fp_check: randomized bench for fp_check against a queue-based reference model.
module tb_fp_check;
    localparam int DEPTH = 8;
`ifdef FP_CHECK_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clock = 1'b0, reset = 1'b1;
    logic        issue_valid = 1'b0, issue_nan_chk = 1'b0, resp_valid = 1'b0;
    logic [63:0] issue_result = '0, resp_result = '0;
    logic [4:0]  issue_flags = '0, resp_flags = '0;
    logic [1:0]  issue_fmt = '0;
    logic        issue_ready, fail, overflow, underflow, idle;
    logic [31:0] pass_count, fail_count;
    logic [63:0] fail_ref_result, fail_calc_result;
    logic [4:0]  fail_ref_flags, fail_calc_flags;

    int tests = 0, fails = 0;

    always #5 clock = ~clock;

    fp_check #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_result(issue_result), .issue_flags(issue_flags),
        .issue_fmt(issue_fmt), .issue_nan_chk(issue_nan_chk),
        .resp_valid(resp_valid), .resp_result(resp_result), .resp_flags(resp_flags),
        .pass_count(pass_count), .fail_count(fail_count), .fail(fail),
        .fail_ref_result(fail_ref_result), .fail_calc_result(fail_calc_result),
        .fail_ref_flags(fail_ref_flags), .fail_calc_flags(fail_calc_flags),
        .overflow(overflow), .underflow(underflow), .idle(idle)
    );

    typedef struct {
        logic [63:0] result;
        logic [4:0]  flags;
        logic [1:0]  fmt;
        logic        nan_chk;
    } exp_t;

    exp_t        m_q[$];
    exp_t        m_pend;
    logic [63:0] m_pend_res, m_fref, m_fcalc;
    logic [4:0]  m_pend_flg, m_freff, m_fcalcf;
    logic [31:0] m_pass, m_failc;
    bit          m_pend_v, m_fail, m_ovf, m_udf, m_halt, m_was_halt;
    int          m_sz;

    // Reference compare: a canonical response NaN relaxes the check to a bit mask.
    function automatic bit ref_match(exp_t e, logic [63:0] calc, logic [4:0] cf);
        logic [63:0] mask;
        if (e.fmt == 2'd1)
            mask = (e.nan_chk && calc == 64'h7FF8000000000000) ? 64'h7FF8000000000000 : {64{1'b1}};
        else
            mask = (e.nan_chk && calc[31:0] == 32'h7FC00000) ? 64'h7FC00000 : 64'hFFFFFFFF;
        return (((e.result ^ calc) & mask) == 64'd0) && (e.flags == cf);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_q.delete();
            m_pend_v = 0; m_fail = 0; m_ovf = 0; m_udf = 0; m_halt = 0;
            m_pass = 0; m_failc = 0; m_fref = 0; m_fcalc = 0; m_freff = 0; m_fcalcf = 0;
        end else begin
            m_was_halt = m_halt;
            m_sz = m_q.size();
            if (!m_was_halt && m_pend_v) begin
                if (ref_match(m_pend, m_pend_res, m_pend_flg)) begin
                    if (m_pass != 32'hFFFFFFFF) m_pass = m_pass + 1;
                end else begin
                    if (m_failc != 32'hFFFFFFFF) m_failc = m_failc + 1;
                    if (!m_fail) begin
                        m_fref = m_pend.result; m_fcalc = m_pend_res;
                        m_freff = m_pend.flags; m_fcalcf = m_pend_flg;
                    end
                    m_fail = 1;
                    if (HALT_EN) m_halt = 1;
                end
            end
            m_pend_v = 0;
            if (!m_was_halt) begin
                if (issue_valid && m_sz >= DEPTH) m_ovf = 1;
                if (resp_valid) begin
                    if (m_sz == 0) m_udf = 1;
                    else begin
                        m_pend = m_q.pop_front();
                        m_pend_res = resp_result; m_pend_flg = resp_flags; m_pend_v = 1;
                    end
                end
                if (issue_valid && m_sz < DEPTH)
                    m_q.push_back('{issue_result, issue_flags, issue_fmt, issue_nan_chk});
            end
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("issue_ready", issue_ready, (!m_halt && m_q.size() < DEPTH));
        chk("pass_count", pass_count, m_pass);
        chk("fail_count", fail_count, m_failc);
        chk("fail", fail, m_fail);
        chk("fail_ref_result", fail_ref_result, m_fref);
        chk("fail_calc_result", fail_calc_result, m_fcalc);
        chk("fail_ref_flags", fail_ref_flags, m_freff);
        chk("fail_calc_flags", fail_calc_flags, m_fcalcf);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_udf);
        chk("idle", idle, (m_q.size() == 0 && !m_pend_v));
    end

    task automatic drive(bit iv, logic [63:0] ir, logic [4:0] ifl, logic [1:0] fm, bit nc,
                         bit rv, logic [63:0] rr, logic [4:0] rf);
        issue_valid = iv; issue_result = ir; issue_flags = ifl; issue_fmt = fm; issue_nan_chk = nc;
        resp_valid = rv; resp_result = rr; resp_flags = rf;
        @(negedge clock);
    endtask

    task automatic idle_cyc(int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_cyc(2);
        reset = 1'b0;
    endtask

    task automatic random_cycle();
        bit          iv, rv;
        logic [1:0]  fm;
        bit          nc;
        logic [63:0] ir, rr;
        logic [4:0]  ifl, rf;
        exp_t        h;
        int          k;
        iv  = $urandom_range(0, 1) == 1;
        fm  = 2'($urandom_range(0, 1));
        nc  = $urandom_range(0, 1) == 1;
        ifl = 5'($urandom);
        ir  = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1)
            ir = (fm == 2'd1) ? {ir[63], 12'hFFF, ir[50:0]} : {ir[63:32], ir[31], 9'h1FF, ir[21:0]};
        rv = $urandom_range(0, 2) != 0;
        rr = {$urandom, $urandom};
        rf = 5'($urandom);
        if (m_q.size() > 0) begin
            h  = m_q[0];
            rf = h.flags;
            rr = (h.fmt == 2'd1) ? h.result : {32'($urandom), h.result[31:0]};
            k  = $urandom_range(0, 9);
            if (k == 0) rr[$urandom_range(0, 63)] ^= 1'b1;
            else if (k == 1) rf[$urandom_range(0, 4)] ^= 1'b1;
            else if (k < 4) rr = (h.fmt == 2'd1) ? 64'h7FF8000000000000 : {32'($urandom), 32'h7FC00000};
        end
        drive(iv, ir, ifl, fm, nc, rv, rr, rf);
    endtask

    initial begin
        @(negedge clock);
        do_reset();
        chk("rst_pass", pass_count, 0);
        chk("rst_idle", idle, 1);
        chk("rst_ready", issue_ready, 1);

        drive(1, 64'h3F800000, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 64'h3F800000, 0);
        idle_cyc(1);
        chk("match_pass", pass_count, 1);
        chk("match_fail", fail, 0);
        chk("match_idle", idle, 1);

        drive(1, 64'h7FC12345, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 64'h7FC00000, 0);
        idle_cyc(1);
        chk("nan_mask_pass", pass_count, 2);
        drive(1, 64'h7FC12345, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 64'h7FC00000, 0);
        idle_cyc(1);
        chk("nan_nochk_fail", fail, 1);
        chk("nan_nochk_ref", fail_ref_result, 64'h7FC12345);
        chk("nan_nochk_calc", fail_calc_result, 64'h7FC00000);
        do_reset();

        drive(1, 64'h3FF0000000000000, 5'h01, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 64'h3FF0000000000000, 5'h00);
        idle_cyc(1);
        chk("flag_fail_count", fail_count, 1);
        chk("flag_ref", fail_ref_flags, 5'h01);
        chk("flag_calc", fail_calc_flags, 5'h00);
        do_reset();

        for (int i = 0; i < DEPTH; i++) drive(1, 64'h100 + 64'(i), 5'(i), 1, 0, 0, 0, 0);
        chk("full_ready", issue_ready, 0);
        drive(1, 64'hDEAD, 0, 1, 0, 0, 0, 0);
        chk("overflow_set", overflow, 1);
        for (int i = 0; i < DEPTH; i++) drive(0, 0, 0, 0, 0, 1, 64'h100 + 64'(i), 5'(i));
        idle_cyc(1);
        chk("drain_pass", pass_count, DEPTH);
        chk("drain_idle", idle, 1);
        drive(1, 64'h55, 0, 1, 0, 1, 64'h55, 0);
        chk("underflow_set", underflow, 1);
        chk("underflow_queued", idle, 0);
        drive(0, 0, 0, 0, 0, 1, 64'h55, 0);
        idle_cyc(1);
        chk("underflow_entry_pass", pass_count, DEPTH + 1);

        do_reset();
        for (int i = 0; i < 4; i++) drive(1, 64'h10 + 64'(i), 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 64'hBAD, 0);
        for (int i = 1; i < 4; i++) drive(0, 0, 0, 0, 0, 1, 64'h10 + 64'(i), 0);
        idle_cyc(2);
        chk("post_fail_count", fail_count, 1);
`ifdef FP_CHECK_HALT_EN
        chk("halt_pass", pass_count, 0);
        chk("halt_ready", issue_ready, 0);
`else
        chk("run_pass", pass_count, 3);
        chk("run_ready", issue_ready, 1);
`endif
        reset = 1'b1;
        idle_cyc(1);
        reset = 1'b0;
        chk("rst2_fail", fail, 0);
        chk("rst2_ready", issue_ready, 1);
        chk("rst2_idle", idle, 1);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                random_cycle();
                reset = 1'b0;
            end else
                random_cycle();
        end
        idle_cyc(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
